uart_rx: RTL

16x-oversampling UART receiver (8N1) for the serial-port unit test. Runs in the system clock domain produced by the clock block, using its system clock and its synchronous reset output. It deserialises one asynchronous RX line into bytes and presents them on a valid/ready handshake with a one-byte holding register. It also flags framing errors and overruns.

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 UART receiver with a one-byte holding
// register on a valid/ready handshake. Flags framing errors (stop bit low)
// and overruns (byte completed while the holding register is still full).
module uart_rx #(
    parameter int BAUD_DIV = 14
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Two-out-of-three vote used to reject single-sample noise.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             sync_a_r;
    logic             rxs_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [3:0]       s_r;
    logic [2:0]       bit_idx_r;
    logic             vote7_r;
    logic             vote8_r;
    logic [7:0]       shift_r;
    logic             deliver_r;

    logic             counting_s;
    logic             tick_s;
    logic             decide_s;
    logic             bit_end_s;
    logic             maj_s;
    logic             deliver_s;
    logic             frame_err_s;

    // Tick and sample-point decode; the divider only runs inside a frame.
    assign counting_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
    assign tick_s     = counting_s && (div_r == DIV_MAX);
    assign decide_s   = tick_s && (s_r == 4'd9);
    assign bit_end_s  = tick_s && (s_r == 4'd15);
    assign maj_s      = majority3(vote7_r, vote8_r, rxs_r);

    // Two-flop synchroniser for the asynchronous line, idling high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_a_r <= 1'b1;
            rxs_r    <= 1'b1;
        end else begin
            sync_a_r <= rx_i;
            rxs_r    <= sync_a_r;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the one-cycle delivery and framing-error strobes.
    always_comb begin
        state_next_s = state_r;
        deliver_s    = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s && maj_s) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // Decide mid-stop-bit so a back-to-back start edge is not missed.
                if (decide_s) begin
                    if (maj_s) begin
                        state_next_s = ST_IDLE;
                        deliver_s    = 1'b1;
                    end else begin
                        state_next_s = ST_BREAK;
                        frame_err_s  = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new frame may start.
                if (rxs_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Oversample divider, sample counter, votes, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r     <= '0;
            s_r       <= 4'd0;
            bit_idx_r <= 3'd0;
            vote7_r   <= 1'b1;
            vote8_r   <= 1'b1;
            shift_r   <= 8'h00;
        end else if (!counting_s) begin
            div_r     <= '0;
            s_r       <= 4'd0;
            bit_idx_r <= 3'd0;
        end else begin
            if (tick_s) begin
                div_r <= '0;
                s_r   <= s_r + 4'd1;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (tick_s && (s_r == 4'd7)) begin
                vote7_r <= rxs_r;
            end
            if (tick_s && (s_r == 4'd8)) begin
                vote8_r <= rxs_r;
            end
            if ((state_r == ST_DATA) && decide_s) begin
                shift_r <= {maj_s, shift_r[7:1]};
            end
            if ((state_r == ST_DATA) && bit_end_s && (bit_idx_r != 3'd7)) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
        end
    end

    // Holding register, handshake and registered status/pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
            deliver_r   <= 1'b0;
        end else begin
            deliver_r   <= deliver_s;
            frame_err_o <= frame_err_s;
            busy_o      <= (state_next_s != ST_IDLE);
            overrun_o   <= 1'b0;
            if (deliver_r) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_r;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
